fifo_rd_packer: RTL and testbench

//  Downstream consumer of the show-ahead (prefetch) async FIFO on its read-clock side.
//  - Pops DATA_WIDTH-bit entries with the FIFO's rd_vld/rd_en handshake.
//  - Packs PACK_NUM entries into one word, little-endian: first entry lands in lane 0.
//  - Presents each word on a valid/ready output with a lane-keep mask.
//  - Supports an explicit flush of a partial word.

---
 rtl/fifo_rd_packer.sv | 113 +++++++++++
 tb/tb_fifo_rd_packer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Read-side packer for a show-ahead FIFO: packs PACK_NUM entries per output word, lane 0 first.
// Optional build macro FIFO_RD_PACKER_SEQ_CHECK_EN adds an incrementing-pattern checker (seq_err_cnt).
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_NUM   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rd_vld,
    input  logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           rd_en,
    input  logic                           flush,
    output logic                           out_vld,
    output logic [DATA_WIDTH*PACK_NUM-1:0] out_data,
    output logic [PACK_NUM-1:0]            out_keep,
    input  logic                           out_rdy,
    output logic [CNT_WIDTH-1:0]           word_cnt
`ifdef FIFO_RD_PACKER_SEQ_CHECK_EN
    ,
    output logic [CNT_WIDTH-1:0]           seq_err_cnt
`endif
);

    localparam int LW = $clog2(PACK_NUM);
    localparam logic [LW-1:0] LAST = LW'(PACK_NUM - 1);

    logic [DATA_WIDTH*PACK_NUM-1:0] acc;
    logic [DATA_WIDTH*PACK_NUM-1:0] word_full;
    logic [PACK_NUM-1:0]            keep_part;
    logic [LW-1:0]                  lane;
    logic                           flush_pend;
    logic                           run;
    logic                           slot_free;
    logic                           pop;
    logic                           emit;

    // run keeps rd_en low through reset and releases it on the first edge afterwards
    assign slot_free = !out_vld || out_rdy;
    assign rd_en     = rd_vld && run && !flush_pend && ((lane != LAST) || slot_free);
    assign pop       = rd_vld && rd_en;
    assign emit      = out_vld && out_rdy;

    always_comb begin
        word_full = acc;
        word_full[DATA_WIDTH*(PACK_NUM-1) +: DATA_WIDTH] = rd_data;
        keep_part = '0;
        for (int i = 0; i < PACK_NUM; i++) begin
            keep_part[i] = (i < int'(lane));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run        <= 1'b0;
            acc        <= '0;
            lane       <= '0;
            flush_pend <= 1'b0;
            out_vld    <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            word_cnt   <= '0;
        end else begin
            run <= 1'b1;
            if (emit) begin
                out_vld  <= 1'b0;
                word_cnt <= word_cnt + 1'b1;
            end
            if (pop) begin
                if (lane == LAST) begin
                    out_data <= word_full;
                    out_keep <= '1;
                    out_vld  <= 1'b1;
                    acc      <= '0;
                    lane     <= '0;
                end else begin
                    acc[DATA_WIDTH*lane +: DATA_WIDTH] <= rd_data;
                    lane <= lane + 1'b1;
                end
            end else if (flush_pend && slot_free) begin
                // a flush that raced a word-completing pop leaves lane==0: nothing to send
                if (lane != '0) begin
                    out_data <= acc;
                    out_keep <= keep_part;
                    out_vld  <= 1'b1;
                end
                acc        <= '0;
                lane       <= '0;
                flush_pend <= 1'b0;
            end
            if (flush && !flush_pend && ((lane != '0) || pop)) begin
                flush_pend <= 1'b1;
            end
        end
    end

`ifdef FIFO_RD_PACKER_SEQ_CHECK_EN
    logic [DATA_WIDTH-1:0] seq_exp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_exp     <= '0;
            seq_err_cnt <= '0;
        end else if (pop) begin
            if ((rd_data != seq_exp) && (seq_err_cnt != {CNT_WIDTH{1'b1}})) begin
                seq_err_cnt <= seq_err_cnt + 1'b1;
            end
            seq_exp <= rd_data + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a queue-based FIFO and packing model feed expected words to a monitor.
module tb_fifo_rd_packer;

    localparam int DW = 8;
    localparam int PN = 4;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            rd_vld = 1'b0;
    logic [DW-1:0]   rd_data = '0;
    logic            rd_en;
    logic            flush = 1'b0;
    logic            out_vld;
    logic [DW*PN-1:0] out_data;
    logic [PN-1:0]   out_keep;
    logic            out_rdy = 1'b0;
    logic [CW-1:0]   word_cnt;
`ifdef FIFO_RD_PACKER_SEQ_CHECK_EN
    logic [CW-1:0]   seq_err_cnt;
`endif

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_NUM(PN), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .rd_vld(rd_vld), .rd_data(rd_data), .rd_en(rd_en),
        .flush(flush), .out_vld(out_vld), .out_data(out_data), .out_keep(out_keep),
        .out_rdy(out_rdy), .word_cnt(word_cnt)
`ifdef FIFO_RD_PACKER_SEQ_CHECK_EN
        , .seq_err_cnt(seq_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW*PN-1:0] data;
        logic [PN-1:0]    keep;
    } word_t;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] pend[$];
    word_t         exp_q[$];
    int            pops;
    int            emit_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model: whatever has been popped is packed in order; a full set or a flush closes a word
    task automatic push_word();
        word_t w;
        w.data = '0;
        w.keep = '0;
        for (int i = 0; i < pend.size(); i++) begin
            w.data[i*DW +: DW] = pend[i];
            w.keep[i] = 1'b1;
        end
        exp_q.push_back(w);
        pend.delete();
    endtask

    task automatic cycle(input bit rdy, input bit fl);
        @(negedge clk);
        rd_vld  = (fifo_q.size() > 0);
        rd_data = rd_vld ? fifo_q[0] : DW'($urandom);
        out_rdy = rdy;
        flush   = fl;
        #1;
        if (!rd_vld) chk("rd_en_without_vld", 64'(rd_en), 64'd0);
        if (rd_vld && rd_en) begin
            pend.push_back(fifo_q.pop_front());
            pops++;
        end
        if (pend.size() == PN) push_word();
        else if (fl && pend.size() > 0) push_word();
    endtask

    task automatic do_reset(input bit clr_fifo);
        @(negedge clk);
        rst_n = 1'b0;
        rd_vld = 1'b0;
        flush = 1'b0;
        pend.delete();
        if (clr_fifo) fifo_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // monitor: pops the scoreboard whenever the sink accepts a word
    initial begin
        logic             prev_stall;
        logic [DW*PN-1:0] prev_data;
        logic [PN-1:0]    prev_keep;
        word_t            w;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_keep  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                exp_q.delete();
                emit_seen  = 0;
                prev_stall = 1'b0;
            end else begin
                chk("word_cnt_track", 64'(word_cnt), 64'(emit_seen % (1 << CW)));
                if (prev_stall) begin
                    chk("hold_data", 64'(out_data), 64'(prev_data));
                    chk("hold_keep", 64'(out_keep), 64'(prev_keep));
                end
                if (out_vld && out_rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 64'(out_data), 64'hDEAD_0000_0000);
                    end else begin
                        w = exp_q.pop_front();
                        chk("word_data", 64'(out_data), 64'(w.data));
                        chk("word_keep", 64'(out_keep), 64'(w.keep));
                    end
                    emit_seen++;
                end
                prev_stall = out_vld && !out_rdy;
                prev_data  = out_data;
                prev_keep  = out_keep;
            end
        end
    end

    initial begin
        // reset behaviour with a valid FIFO head waiting
        rd_vld = 1'b1;
        #22;
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_keep", 64'(out_keep), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rd_en_before_first_edge", 64'(rd_en), 64'd0);
        @(posedge clk);
        #1;
        chk("rd_en_after_first_edge", 64'(rd_en), 64'd1);

        // stream of 0x00..0x0F with a ready sink
        do_reset(1);
        for (int i = 0; i < 16; i++) fifo_q.push_back(DW'(i));
        pops = 0;
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0);
        chk("stream_pops", 64'(pops), 64'd16);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
        chk("stream_word_cnt", 64'(word_cnt), 64'd4);

        // backpressure after the first word
        do_reset(1);
        for (int i = 0; i < 16; i++) fifo_q.push_back(DW'(i));
        pops = 0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
        chk("bp_first_pops", 64'(pops), 64'd4);
        pops = 0;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);
        chk("bp_stalled_pops", 64'(pops), 64'd3);
        chk("bp_out_vld", 64'(out_vld), 64'd1);
        chk("bp_out_data", 64'(out_data), 64'h03020100);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
        chk("bp_fifo_drained", 64'(fifo_q.size()), 64'd0);
        chk("bp_word_cnt", 64'(word_cnt), 64'd4);

        // partial-word flush, then a flush with nothing buffered
        do_reset(1);
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        chk("flush_data", 64'(out_data), 64'h0000BBAA);
        chk("flush_keep", 64'(out_keep), 64'h3);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
        chk("empty_flush_word_cnt", 64'(word_cnt), 64'd1);
        chk("empty_flush_out_vld", 64'(out_vld), 64'd0);

        // reset in the middle of a word
        do_reset(1);
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(i));
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        do_reset(0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
        chk("midrst_word_cnt", 64'(word_cnt), 64'd2);

        // randomized traffic with gaps, backpressure and flushes
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2) != 0) fifo_q.push_back(DW'($urandom));
            cycle($urandom_range(3) != 0, $urandom_range(19) == 0);
        end
        for (int i = 0; i < 400 && fifo_q.size() > 0; i++) cycle(1'b1, 1'b0);
        chk("rand_fifo_drained", 64'(fifo_q.size()), 64'd0);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
        chk("rand_scoreboard_empty", 64'(exp_q.size()), 64'd0);

`ifdef FIFO_RD_PACKER_SEQ_CHECK_EN
        do_reset(1);
        fifo_q.push_back(8'd0); fifo_q.push_back(8'd1); fifo_q.push_back(8'd2);
        fifo_q.push_back(8'd7); fifo_q.push_back(8'd8);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
        chk("seq_err_one", 64'(seq_err_cnt), 64'd1);
        do_reset(1);
        for (int i = 0; i < 256; i++) fifo_q.push_back(DW'(i));
        fifo_q.push_back(8'd0);
        for (int i = 0; i < 270; i++) cycle(1'b1, 1'b0);
        chk("seq_err_wrap", 64'(seq_err_cnt), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
